// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: builds a 6-byte SD SPI-mode command, shifts it out on SPI mode 0 and captures the R1 reply.
// Define SD_CRC7_EN to compute the real CRC7; otherwise the CRC byte is the constant 0x95.
module sd_cmd_framer #(
  parameter int CLK_DIV   = 4,
  parameter int RESP_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);
  // state  | meaning
  // IDLE   | cs_n high, waiting for start
  // SEND   | shifting the 48 command bits out on mosi
  // WAIT   | clocking with mosi high, looking for the R1 start bit
  // RECV   | collecting the remaining seven R1 bits
  // FINISH | one-cycle done pulse, then release cs_n

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WIN_BITS = 8 * RESP_WAIT;
  localparam int WIN_W    = $clog2(WIN_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [5:0]       bit_idx, bit_idx_nxt;
  logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
  logic [2:0]       rx_cnt, rx_cnt_nxt;
  logic [47:0]      pkt, pkt_nxt;
  logic [7:0]       rx_sh, rx_sh_nxt;
  logic [7:0]       resp_nxt;
  logic             timeout_nxt;
  logic             sclk_nxt;
  logic             cs_n_nxt;
  logic             busy_nxt;

  logic [7:0]       crc_byte;
  logic [47:0]      pkt_load;
  logic             tick, rise, fall;

`ifdef SD_CRC7_EN
  // CRC7 (x^7 + x^3 + 1, init 0) over the command byte and argument, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  assign crc_byte = {crc7({2'b01, cmd_idx, cmd_arg}), 1'b1};
`else
  assign crc_byte = 8'h95;
`endif

  assign pkt_load = {2'b01, cmd_idx, cmd_arg, crc_byte};

  // pkt refills with ones as it shifts, so mosi idles high without a separate register
  assign mosi = pkt[47];

  assign tick = (div_cnt == DIV_LAST);
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_idx_nxt = bit_idx;
    win_cnt_nxt = win_cnt;
    rx_cnt_nxt  = rx_cnt;
    pkt_nxt     = pkt;
    rx_sh_nxt   = rx_sh;
    resp_nxt    = resp;
    timeout_nxt = timeout;
    sclk_nxt    = sclk;
    cs_n_nxt    = cs_n;
    busy_nxt    = busy;
    done        = 1'b0;

    if (state == S_SEND || state == S_WAIT || state == S_RECV) begin
      div_cnt_nxt = tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        sclk_nxt = ~sclk;
      end
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_SEND;
          pkt_nxt     = pkt_load;
          div_cnt_nxt = '0;
          bit_idx_nxt = '0;
          sclk_nxt    = 1'b0;
          cs_n_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          timeout_nxt = 1'b0;
        end
      end

      S_SEND: begin
        if (fall) begin
          pkt_nxt = {pkt[46:0], 1'b1};
          if (bit_idx == 6'd47) begin
            state_nxt   = S_WAIT;
            win_cnt_nxt = WIN_LAST;
          end else begin
            bit_idx_nxt = bit_idx + 6'd1;
          end
        end
      end

      S_WAIT: begin
        if (rise && !miso) begin
          // first zero anywhere in the window is R1 bit 7
          state_nxt  = S_RECV;
          rx_sh_nxt  = {rx_sh[6:0], 1'b0};
          rx_cnt_nxt = 3'd1;
        end else if (fall) begin
          if (win_cnt == '0) begin
            state_nxt   = S_FINISH;
            resp_nxt    = 8'hFF;
            timeout_nxt = 1'b1;
          end else begin
            win_cnt_nxt = win_cnt - WIN_W'(1);
          end
        end
      end

      S_RECV: begin
        if (rise) begin
          rx_sh_nxt  = {rx_sh[6:0], miso};
          rx_cnt_nxt = rx_cnt + 3'd1;
        end else if (fall && rx_cnt == 3'd0) begin
          // rx_cnt wraps to 0 once all eight bits are in
          state_nxt = S_FINISH;
          resp_nxt  = rx_sh;
        end
      end

      S_FINISH: begin
        done        = 1'b1;
        state_nxt   = S_IDLE;
        cs_n_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        div_cnt_nxt = '0;
        sclk_nxt    = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_idx <= '0;
      win_cnt <= '0;
      rx_cnt  <= '0;
      pkt     <= '1;
      rx_sh   <= '1;
      resp    <= 8'hFF;
      timeout <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      win_cnt <= win_cnt_nxt;
      rx_cnt  <= rx_cnt_nxt;
      pkt     <= pkt_nxt;
      rx_sh   <= rx_sh_nxt;
      resp    <= resp_nxt;
      timeout <= timeout_nxt;
      sclk    <= sclk_nxt;
      cs_n    <= cs_n_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// tb_sd_cmd_framer: table-driven and randomized command frames checked against a packet/timing model,
// plus hand sequences for ignored start, reset mid-frame and back-to-back commands.
module tb_sd_cmd_framer;
  localparam int D  = 2;
  localparam int RW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        busy, done, timeout, sclk, mosi, cs_n;
  logic [7:0]  resp;
  logic        miso = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  sd_cmd_framer #(.CLK_DIV(D), .RESP_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .busy(busy), .done(done), .resp(resp), .timeout(timeout),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          k;
    logic [7:0]  r1;
    int          poke;
    logic [7:0]  exp_crc;
    logic [7:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // CRC byte as the remainder of body*x^7 divided by x^7+x^3+1
  function automatic logic [7:0] model_crc(input logic [39:0] body);
`ifdef SD_CRC7_EN
    logic [46:0] v;
    logic [46:0] g;
    v = {body, 7'b0};
    g = 47'h89;
    for (int b = 46; b >= 7; b--) begin
      if (v[b]) v = v ^ (g << (b - 7));
    end
    return {v[6:0], 1'b1};
`else
    return 8'h95;
`endif
  endfunction

  function automatic logic [47:0] model_pkt(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, model_crc(body)};
  endfunction

  task automatic accept(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clk);
    cmd_idx = idx;
    cmd_arg = arg;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the sample point one cycle after the accept edge (s = 1).
  task automatic run_frame(input logic [47:0] exp_pkt, input int k, input logic [7:0] r1,
                           input logic [7:0] exp_resp, input logic exp_to, input int poke,
                           input logic b2b, input logic [5:0] nidx, input logic [31:0] narg,
                           output logic [47:0] got);
    logic stream[128];
    int   s, rises, falls, done_s, limit, exp_done;
    logic prev_sclk;
    logic [7:0] resp_at_done;
    for (int j = 0; j < 128; j++) stream[j] = 1'b1;
    if (k >= 0) for (int j = 0; j < 8; j++) stream[k + j] = r1[7 - j];
    exp_done = (k < 0) ? 1 + 2 * D * (48 + 8 * RW) : 1 + 2 * D * (48 + k + 8);
    limit = 2 * D * (56 + 8 * RW) + 40;
    got = '1;
    rises = 0;
    falls = 0;
    done_s = -1;
    prev_sclk = 1'b0;
    resp_at_done = 8'h00;
    miso = 1'b1;
    chk("busy_after_accept", busy, 1'b1);
    chk("cs_n_after_accept", cs_n, 1'b0);
    chk("mosi_first_bit", mosi, exp_pkt[47]);
    s = 1;
    while (s <= limit && done_s < 0) begin
      if (sclk && !prev_sclk) begin
        if (rises == 0) chk("first_rise_time", s, 1 + D);
        if (rises < 48) got[47 - rises] = mosi;
        rises++;
      end
      if (!sclk && prev_sclk) begin
        falls++;
        if (falls >= 48 && falls - 48 < 128) miso = stream[falls - 48];
      end
      prev_sclk = sclk;
      if (poke != 0 && s == poke) begin
        start = 1'b1;
        cmd_idx = ~cmd_idx;
        cmd_arg = ~cmd_arg;
      end else if (poke != 0 && s == poke + 1) begin
        start = 1'b0;
      end
      if (done) begin
        done_s = s;
        resp_at_done = resp;
        chk("done_time", s, exp_done);
        chk("resp", resp, exp_resp);
        chk("timeout", timeout, exp_to);
        chk("busy_at_done", busy, 1'b1);
        chk("mosi_idle_at_done", mosi, 1'b1);
        chk("sclk_low_at_done", sclk, 1'b0);
        if (b2b) begin
          start = 1'b1;
          cmd_idx = nidx;
          cmd_arg = narg;
        end
      end
      @(posedge clk);
      @(negedge clk);
      s++;
    end
    chk("done_seen", done_s >= 0, 1'b1);
    chk("packet", got, exp_pkt);
    chk("done_one_cycle", done, 1'b0);
    chk("cs_n_after_done", cs_n, 1'b1);
    chk("busy_after_done", busy, 1'b0);
    chk("resp_hold", resp, resp_at_done);
    miso = 1'b1;
  endtask

  initial begin
    logic [47:0] got;
    logic [47:0] ep;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [7:0]  rr1;
    int          rk;
    int          dcount;

`ifdef SD_CRC7_EN
    vecs[0] = '{6'd0,  32'h0000_0000, 13, 8'h01, 0,  8'h95, 8'h01, 1'b0};
    vecs[1] = '{6'd8,  32'h0000_01AA, 0,  8'h01, 0,  8'h87, 8'h01, 1'b0};
    vecs[2] = '{6'd17, 32'h0000_0000, -1, 8'h00, 0,  8'h55, 8'hFF, 1'b1};
`else
    vecs[0] = '{6'd0,  32'h0000_0000, 13, 8'h01, 0,  8'h95, 8'h01, 1'b0};
    vecs[1] = '{6'd8,  32'h0000_01AA, 0,  8'h01, 0,  8'h95, 8'h01, 1'b0};
    vecs[2] = '{6'd17, 32'h0000_0000, -1, 8'h00, 0,  8'h95, 8'hFF, 1'b1};
`endif
    vecs[3] = '{6'd55, 32'h0000_0000, 3,  8'h05, 30, model_crc({2'b01, 6'd55, 32'h0}), 8'h05, 1'b0};
    vecs[4] = '{6'd41, 32'h4000_0000, 15, 8'h00, 0,  model_crc({2'b01, 6'd41, 32'h4000_0000}), 8'h00, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b1);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_resp", resp, 8'hFF);

    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].idx, vecs[i].arg);
      run_frame(model_pkt(vecs[i].idx, vecs[i].arg), vecs[i].k, vecs[i].r1,
                vecs[i].exp_resp, vecs[i].exp_to, vecs[i].poke, 1'b0, 6'd0, 32'd0, got);
      chk("crc_byte", got[7:0], vecs[i].exp_crc);
    end

    for (int i = 0; i < 6; i++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      rk   = int'($urandom_range(0, 16)) - 1;
      rr1  = 8'($urandom_range(0, 127));
      accept(ridx, rarg);
      run_frame(model_pkt(ridx, rarg), rk, rr1, (rk < 0) ? 8'hFF : rr1, rk < 0,
                0, 1'b0, 6'd0, 32'd0, got);
    end

    // back-to-back: start raised in the done cycle is taken once the block is idle
    accept(6'd0, 32'd0);
    run_frame(model_pkt(6'd0, 32'd0), 5, 8'h01, 8'h01, 1'b0, 0, 1'b1, 6'd17, 32'h0000_1234, got);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    run_frame(model_pkt(6'd17, 32'h0000_1234), 2, 8'h00, 8'h00, 1'b0, 0, 1'b0, 6'd0, 32'd0, got);

    // reset in the middle of packet bit 20
    accept(6'd24, 32'hDEAD_BEEF);
    repeat (2 * D * 20 + 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_frame_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sclk", sclk, 1'b0);
    chk("midrst_mosi", mosi, 1'b1);
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    dcount = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || sclk || !cs_n) dcount++;
    end
    chk("midrst_quiet", dcount, 0);
    accept(6'd0, 32'd0);
    run_frame(model_pkt(6'd0, 32'd0), 13, 8'h01, 8'h01, 1'b0, 0, 1'b0, 6'd0, 32'd0, got);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
